// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for an RV32I pipeline.
// A shadow pipeline of decoded register-usage records (slot 0 = EX,
// slot NUM_STAGES = WB) drives EX forward selects, ID regfile bypass,
// load-use stalls and saturating event counters.
module fwd_hazard_ctrl #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1),
    parameter int unsigned CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic             i_id_valid,
    input  logic [31:0]      i_id_inst,
    output logic             o_stall,
    output logic             o_fwd_rs1_sel,
    output logic             o_fwd_rs2_sel,
    output logic [SEL_W-1:0] o_fwd_a_sel,
    output logic [SEL_W-1:0] o_fwd_b_sel,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_fwd_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       wren;
        logic       is_load;
    } slot_t;

    function automatic slot_t decode(input logic [31:0] inst);
        slot_t d;
        d       = '0;
        d.valid = 1'b1;
        d.rd    = inst[11:7];
        d.rs1   = inst[19:15];
        d.rs2   = inst[24:20];
        case (inst[6:0])
            OpLui, OpAuipc, OpJal: d.wren = 1'b1;
            OpJalr: begin
                d.wren = 1'b1;
                d.use1 = 1'b1;
            end
            OpBranch, OpStore: begin
                d.use1 = 1'b1;
                d.use2 = 1'b1;
            end
            OpLoad: begin
                d.wren    = 1'b1;
                d.use1    = 1'b1;
                d.is_load = 1'b1;
            end
            OpImm: begin
                d.wren = 1'b1;
                d.use1 = 1'b1;
            end
            OpReg: begin
                d.wren = 1'b1;
                d.use1 = 1'b1;
                d.use2 = 1'b1;
            end
            default: ;
        endcase
        // x0 writes are architecturally invisible, so never forward them.
        if (d.rd == 5'd0) d.wren = 1'b0;
        return d;
    endfunction

    slot_t [NUM_STAGES:0] slot_q, slot_d;
    slot_t                id_dec;
    logic [SEL_W-1:0]     fwd_a_sel, fwd_b_sel;
    logic                 load_hit;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     fwd_cnt_q, fwd_cnt_d;

    // Source fields of older slots are carried only to keep the record uniform.
    logic unused_slot_bits;
    assign unused_slot_bits = ^slot_q;

    assign id_dec = decode(i_id_inst);

    // EX forward selects: scan oldest to youngest so the nearest stage wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        if (slot_q[0].valid) begin
            for (int k = int'(NUM_STAGES); k >= 1; k--) begin
                if (slot_q[k].valid && slot_q[k].wren) begin
                    if (slot_q[0].use1 && (slot_q[k].rd == slot_q[0].rs1)) fwd_a_sel = SEL_W'(k);
                    if (slot_q[0].use2 && (slot_q[k].rd == slot_q[0].rs2)) fwd_b_sel = SEL_W'(k);
                end
            end
        end
    end

    // Load-use detection against every slot whose load data is not yet available.
    always_comb begin
        load_hit = 1'b0;
        for (int s = 0; s < int'(LOAD_LAT); s++) begin
            if (slot_q[s].valid && slot_q[s].is_load &&
                ((id_dec.use1 && (slot_q[s].rd == id_dec.rs1)) ||
                 (id_dec.use2 && (slot_q[s].rd == id_dec.rs2)))) begin
                load_hit = 1'b1;
            end
        end
    end

    assign o_stall     = i_id_valid & ~i_flush & load_hit;
    assign o_fwd_a_sel = fwd_a_sel;
    assign o_fwd_b_sel = fwd_b_sel;

    assign o_fwd_rs1_sel = i_id_valid & id_dec.use1 & slot_q[NUM_STAGES].valid &
                           slot_q[NUM_STAGES].wren & (slot_q[NUM_STAGES].rd == id_dec.rs1);
    assign o_fwd_rs2_sel = i_id_valid & id_dec.use2 & slot_q[NUM_STAGES].valid &
                           slot_q[NUM_STAGES].wren & (slot_q[NUM_STAGES].rd == id_dec.rs2);

    // Shadow pipeline advance; stalled or flushed ID inserts a bubble into EX.
    always_comb begin
        slot_d = slot_q;
        if (!i_hold) begin
            for (int k = int'(NUM_STAGES); k >= 1; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0] = (i_id_valid && !o_stall && !i_flush) ? id_dec : '0;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!i_hold) begin
            if (o_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (slot_q[0].valid && ((fwd_a_sel != '0) || (fwd_b_sel != '0)) &&
                (fwd_cnt_q != '1)) begin
                fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_fwd_cnt   = fwd_cnt_q;

endmodule
